ps2_keyboard_decoder: RTL and testbench

- Upstream stage of the player block and of any other key consumer.
- Receives raw PS/2 keyboard clock/data lines, deframes 11-bit PS/2 frames and resolves the 0xE0 (extended) and 0xF0 (break) prefixes.
- Emits a 9-bit keyCode with one-cycle make/brake strobes, directly consumable by the keyToggle_decoder instances.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_input_filter.sv | 65 ++++++
 rtl/ps2_keyboard_decoder.sv | 165 ++++++++++++++++
 tb/tb_ps2_keyboard_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions: prefix bytes, decoder FSM states,
// game key codes and the frame parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DECODE = 3'd4
    } ps2_state_t;

    // Game keys as {ext, scan code}
    localparam logic [8:0] KEY_UP    = 9'h075;
    localparam logic [8:0] KEY_DOWN  = 9'h073;
    localparam logic [8:0] KEY_RIGHT = 9'h074;
    localparam logic [8:0] KEY_LEFT  = 9'h06B;
    localparam logic [8:0] KEY_FIRE  = 9'h029;

    // PS/2 uses odd parity over the 8 data bits plus the parity bit
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the raw PS/2 lines into the clk domain, glitch-filters the
// PS/2 clock and reports its falling edges together with a data sample.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic falling_edge,
    output logic data_sample
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          filt_clk_r;
    logic          filt_clk_s;
    logic [CW-1:0] filt_cnt_r;
    logic [CW-1:0] filt_cnt_s;
    logic          fall_s;
    logic          falling_edge_r;
    logic          data_sample_r;

    // Filter: change only after FILTER_LEN consecutive samples differing from the current value
    always_comb begin
        filt_clk_s = filt_clk_r;
        filt_cnt_s = filt_cnt_r;
        if (clk_sync_r[1] != filt_clk_r) begin
            if (filt_cnt_r == CW'(FILTER_LEN - 1)) begin
                filt_clk_s = clk_sync_r[1];
                filt_cnt_s = {CW{1'b0}};
            end else begin
                filt_cnt_s = filt_cnt_r + CW'(1);
            end
        end else begin
            filt_cnt_s = {CW{1'b0}};
        end
        fall_s = filt_clk_r & ~filt_clk_s;
    end

    // Synchronizer, filter state and registered edge/data outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_r     <= 2'b11;
            data_sync_r    <= 2'b11;
            filt_clk_r     <= 1'b1;
            filt_cnt_r     <= {CW{1'b0}};
            falling_edge_r <= 1'b0;
            data_sample_r  <= 1'b1;
        end else begin
            clk_sync_r     <= {clk_sync_r[0], ps2_clk};
            data_sync_r    <= {data_sync_r[0], ps2_data};
            filt_clk_r     <= filt_clk_s;
            filt_cnt_r     <= filt_cnt_s;
            falling_edge_r <= fall_s;
            data_sample_r  <= data_sync_r[1];
        end
    end

    assign falling_edge = falling_edge_r;
    assign data_sample  = data_sample_r;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard receiver: deframes 11-bit frames, resolves the E0/F0
// prefixes and emits {ext, scan code} with one-cycle make/brake strobes.
module ps2_keyboard_decoder
    import ps2_pkg::*;
#(
    parameter int KEYCODE_WIDTH  = 9,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [KEYCODE_WIDTH-1:0] keyCode,
    output logic                     make,
    output logic                     brake,
    output logic                     frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fall_s;
    logic data_s;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk          (clk),
        .resetN       (resetN),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .falling_edge (fall_s),
        .data_sample  (data_s)
    );

    ps2_state_t              state_r,    state_s;
    logic [2:0]              bit_cnt_r,  bit_cnt_s;
    logic [7:0]              shift_r,    shift_s;
    logic                    parity_r,   parity_s;
    logic                    ext_r,      ext_s;
    logic                    brk_r,      brk_s;
    logic [TW-1:0]           tmo_r,      tmo_s;
    logic [KEYCODE_WIDTH-1:0] key_code_r, key_code_s;
    logic                    make_r,     make_s;
    logic                    brake_r,    brake_s;
    logic                    ferr_r,     ferr_s;

    // Next-state, datapath and strobe logic; strobes default low every cycle
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        ext_s      = ext_r;
        brk_s      = brk_r;
        tmo_s      = tmo_r;
        key_code_s = key_code_r;
        make_s     = 1'b0;
        brake_s    = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                tmo_s = {TW{1'b0}};
                if (fall_s) begin
                    if (!data_s) begin
                        state_s   = DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DATA, PARITY, STOP: begin
                if (fall_s) begin
                    tmo_s = {TW{1'b0}};
                    if (state_r == DATA) begin
                        shift_s = {data_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_s = PARITY;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 3'd1;
                        end
                    end else if (state_r == PARITY) begin
                        parity_s = data_s;
                        state_s  = STOP;
                    end else begin
                        if (data_s && odd_parity_ok(shift_r, parity_r)) begin
                            state_s = DECODE;
                        end else begin
                            ferr_s  = 1'b1;
                            ext_s   = 1'b0;
                            brk_s   = 1'b0;
                            state_s = IDLE;
                        end
                    end
                end else if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Device stopped clocking mid-frame: abandon the frame
                    ferr_s  = 1'b1;
                    ext_s   = 1'b0;
                    brk_s   = 1'b0;
                    tmo_s   = {TW{1'b0}};
                    state_s = IDLE;
                end else begin
                    tmo_s = tmo_r + TW'(1);
                end
            end
            DECODE: begin
                tmo_s   = {TW{1'b0}};
                state_s = IDLE;
                if (shift_r == PS2_EXT_PREFIX) begin
                    ext_s = 1'b1;
                end else if (shift_r == PS2_BREAK_PREFIX) begin
                    brk_s = 1'b1;
                end else begin
                    key_code_s = KEYCODE_WIDTH'({ext_r, shift_r});
                    make_s     = ~brk_r;
                    brake_s    = brk_r;
                    ext_s      = 1'b0;
                    brk_s      = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                tmo_s   = {TW{1'b0}};
                ext_s   = 1'b0;
                brk_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            ext_r      <= 1'b0;
            brk_r      <= 1'b0;
            tmo_r      <= {TW{1'b0}};
            key_code_r <= {KEYCODE_WIDTH{1'b0}};
            make_r     <= 1'b0;
            brake_r    <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            ext_r      <= ext_s;
            brk_r      <= brk_s;
            tmo_r      <= tmo_s;
            key_code_r <= key_code_s;
            make_r     <= make_s;
            brake_r    <= brake_s;
            ferr_r     <= ferr_s;
        end
    end

    assign keyCode     = key_code_r;
    assign make        = make_r;
    assign brake       = brake_r;
    assign frame_error = ferr_r;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Bench for ps2_keyboard_decoder: directed frame table, hand-written corner
// sequences, and random frames checked against a prefix-level key model.
module tb_ps2_keyboard_decoder;

    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetN;
    logic       ps2_clk;
    logic       ps2_data;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       frame_error;

    ps2_keyboard_decoder #(
        .KEYCODE_WIDTH  (9),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keyCode     (keyCode),
        .make        (make),
        .brake       (brake),
        .frame_error (frame_error)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mk_cnt = 0, br_cnt = 0, er_cnt = 0, both_cnt = 0;

    // Strobe monitor, sampled on the falling clk edge
    always @(negedge clk) begin
        if (make)          mk_cnt++;
        if (brake)         br_cnt++;
        if (frame_error)   er_cnt++;
        if (make && brake) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Device-style transmission: data changes while clock high, read on fall
    task automatic send_bits(input logic [10:0] bits, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF / 2);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] b, input bit bp, input bit bs,
                             input int emk, input int ebr, input int eer, input int ecode);
        int m0, b0, e0;
        m0 = mk_cnt; b0 = br_cnt; e0 = er_cnt;
        send_bits(frame_bits(b, bp, bs), 0, 11);
        ps2_data = 1'b1;
        wait_clk(30);
        check({name, ".make"},  mk_cnt - m0, emk);
        check({name, ".brake"}, br_cnt - b0, ebr);
        check({name, ".err"},   er_cnt - e0, eer);
        check({name, ".code"},  int'(keyCode), ecode);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         bp;
        bit         bs;
        int         emk;
        int         ebr;
        int         eer;
        int         ecode;
    } vec_t;

    vec_t vt[18];

    initial begin
        int m0, b0, e0, n;
        logic [7:0] rb;
        bit rbp, rbs;
        bit m_ext, m_brk;
        int m_code, emk, ebr, eer;

        resetN = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(3);
        check("rst.code",  int'(keyCode), 0);
        check("rst.make",  int'(make), 0);
        check("rst.brake", int'(brake), 0);
        check("rst.err",   int'(frame_error), 0);
        resetN = 1'b1;
        wait_clk(10);

        // Directed frames: {byte, bad parity, bad stop, makes, brakes, errors, keyCode after}
        vt[0]  = '{8'h75, 1'b0, 1'b0, 1, 0, 0, 32'h075};
        vt[1]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 32'h075};
        vt[2]  = '{8'h75, 1'b0, 1'b0, 0, 1, 0, 32'h075};
        vt[3]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h075};
        vt[4]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 32'h075};
        vt[5]  = '{8'h6B, 1'b0, 1'b0, 0, 1, 0, 32'h16B};
        vt[6]  = '{8'h6B, 1'b0, 1'b0, 1, 0, 0, 32'h06B};
        vt[7]  = '{8'h74, 1'b1, 1'b0, 0, 0, 1, 32'h06B};
        vt[8]  = '{8'h74, 1'b0, 1'b0, 1, 0, 0, 32'h074};
        vt[9]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h074};
        vt[10] = '{8'h74, 1'b0, 1'b1, 0, 0, 1, 32'h074};
        vt[11] = '{8'h74, 1'b0, 1'b0, 1, 0, 0, 32'h074};
        vt[12] = '{8'hF0, 1'b0, 1'b0, 0, 0, 0, 32'h074};
        vt[13] = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h074};
        vt[14] = '{8'h75, 1'b0, 1'b0, 0, 1, 0, 32'h175};
        vt[15] = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h175};
        vt[16] = '{8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h175};
        vt[17] = '{8'h72, 1'b0, 1'b0, 1, 0, 0, 32'h172};
        for (int i = 0; i < 18; i++) begin
            run_frame($sformatf("vec%0d", i), vt[i].b, vt[i].bp, vt[i].bs,
                      vt[i].emk, vt[i].ebr, vt[i].eer, vt[i].ecode);
        end

        // Latency: strobe shortly after the stop-bit clock fall, exactly one cycle long
        m0 = mk_cnt;
        send_bits(frame_bits(8'h29, 1'b0, 1'b0), 0, 10);
        ps2_data = 1'b1;
        wait_clk(HALF / 2);
        ps2_clk = 1'b0;
        n = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (make) begin
                n = k;
                break;
            end
        end
        check("lat.window", int'(n >= 7 && n <= 11), 1);
        wait_clk(HALF);
        ps2_clk = 1'b1;
        wait_clk(30);
        check("lat.count", mk_cnt - m0, 1);
        check("lat.code", int'(keyCode), 32'h029);

        // Short ps2_clk glitches on an idle line must not disturb a pending E0
        run_frame("gl.e0", 8'hE0, 1'b0, 1'b0, 0, 0, 0, 32'h029);
        m0 = mk_cnt; e0 = er_cnt;
        for (int g = 1; g <= 3; g++) begin
            ps2_clk = 1'b0;
            wait_clk(g);
            ps2_clk = 1'b1;
            wait_clk(12);
        end
        check("gl.err",  er_cnt - e0, 0);
        check("gl.make", mk_cnt - m0, 0);
        run_frame("gl.after", 8'h75, 1'b0, 1'b0, 1, 0, 0, 32'h175);

        // Timeout: partial frame then a silent clock line
        m0 = mk_cnt; e0 = er_cnt;
        send_bits(frame_bits(8'h73, 1'b0, 1'b0), 0, 5);
        ps2_data = 1'b1;
        wait_clk(TMO - 100);
        check("tmo.early", er_cnt - e0, 0);
        wait_clk(200);
        check("tmo.err",  er_cnt - e0, 1);
        check("tmo.make", mk_cnt - m0, 0);
        run_frame("tmo.after", 8'h73, 1'b0, 1'b0, 1, 0, 0, 32'h073);

        // Reset mid-frame: outputs clear at once, the frame tail never makes a key
        send_bits(frame_bits(8'h74, 1'b0, 1'b0), 0, 4);
        resetN = 1'b0;
        #2;
        check("mrst.code",  int'(keyCode), 0);
        check("mrst.make",  int'(make), 0);
        check("mrst.brake", int'(brake), 0);
        check("mrst.err",   int'(frame_error), 0);
        wait_clk(3);
        resetN = 1'b1;
        wait_clk(5);
        m0 = mk_cnt; b0 = br_cnt;
        send_bits(frame_bits(8'h74, 1'b0, 1'b0), 4, 7);
        ps2_data = 1'b1;
        wait_clk(TMO + 100);
        check("mrst.tail_make",  mk_cnt - m0, 0);
        check("mrst.tail_brake", br_cnt - b0, 0);
        check("mrst.tail_code",  int'(keyCode), 0);

        // Random frames against a prefix-level model of the keyboard protocol
        m_ext = 1'b0; m_brk = 1'b0; m_code = 0;
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hE0;
                2, 3:    rb = 8'hF0;
                default: begin
                    rb = 8'($urandom_range(0, 255));
                    if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h1C;
                end
            endcase
            n = $urandom_range(0, 9);
            rbp = (n == 0);
            rbs = (n == 1);
            emk = 0; ebr = 0; eer = 0;
            if (rbp || rbs) begin
                eer = 1; m_ext = 1'b0; m_brk = 1'b0;
            end else if (rb == 8'hE0) begin
                m_ext = 1'b1;
            end else if (rb == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                emk = m_brk ? 0 : 1;
                ebr = m_brk ? 1 : 0;
                m_code = (m_ext ? 256 : 0) + int'(rb);
                m_ext = 1'b0; m_brk = 1'b0;
            end
            run_frame($sformatf("rnd%0d", r), rb, rbp, rbs, emk, ebr, eer, m_code);
        end

        check("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
